reglist_decoder: RTL and testbench
==================================

# reglist_decoder

Inverse of the register-list priority encoder: receives register indices one per handshake, decodes each to one-hot, and accumulates them into a register-list mask. It sits on the LDM/STM retirement path. It rebuilds the mask of registers actually written, with a count, and hands the completed list downstream on the final beat.

## Interface
- `MASK_WIDTH`, default 16: width of the register-list mask.
- `IDX_WIDTH`, default `$clog2(MASK_WIDTH)`: width of the incoming index.
- `CLK` input, 1 bit: clock; all state updates on the rising edge.
- `Reset` input, 1 bit: synchronous, active-high reset.
- `in_valid` input, 1 bit: an index beat is offered.
- `in_ready` output, 1 bit: the block can accept a beat.
- `in_idx` input, `IDX_WIDTH` bits: register index to set in the mask.
- `in_last` input, 1 bit: this beat closes the list.
- `out_valid` output, 1 bit: the completed list is presented.
- `out_ready` input, 1 bit: the consumer takes the list.
- `out_mask` output, `MASK_WIDTH` bits: accumulated one-hot OR of the accepted indices.
- `out_count` output, `IDX_WIDTH+1` bits: number of distinct bits set in `out_mask`.
- `out_dup` output, 1 bit: some index arrived more than once in this list.
- `out_err` output, 1 bit: some index was ≥ `MASK_WIDTH`.

## Operation
- States:
  - IDLE: no beats yet.
  - COLLECT: at least one beat accepted, `in_last` not yet seen.
  - DONE: list complete.
- `in_ready` = 1 in IDLE and COLLECT; 0 in DONE.
- A beat is accepted when `in_valid && in_ready`.
- Accepted beat, valid index: `mask |= 1<<in_idx`.
  - Count increments only if that bit was previously 0.
  - If the bit was already 1, the sticky dup flag is set.
- Accepted beat with `in_idx ≥ MASK_WIDTH`: mask and count unchanged, sticky err flag set.
- State transitions on an accepted beat:
  - `in_last`=0: go to COLLECT (from IDLE or COLLECT).
  - `in_last`=1: go to DONE (from IDLE or COLLECT). A single-beat list is legal.
- DONE:
  - `out_valid`=1; `out_mask`, `out_count`, `out_dup` and `out_err` hold stable.
  - On `out_ready`: return to IDLE and clear mask, count, dup and err in the same edge.
- `out_*` data is don't-care when `out_valid`=0. Drive the internal accumulators; the bench checks data only with `out_valid`.
- `out_count` saturates naturally at `MASK_WIDTH`. Width `IDX_WIDTH+1` holds 16 for the default.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `out_mask`=0, `out_count`=0, `out_dup`=0, `out_err`=0.
- Latency: a last beat accepted at edge N gives `out_valid`=1 after edge N. The outputs are registered, with no combinational path from in_* to out_*.
- `in_ready` depends on state only, with no combinational path from `out_ready`.
- No accept and deliver in the same cycle: a new list can start at the earliest one cycle after the `out_ready` handshake. Throughput is (beats+1) cycles per list.
- `out_ready` asserted while `out_valid`=0 is ignored.
- `in_valid` with `in_ready`=0 (DONE) is not consumed. The producer must hold the beat.
- Reset mid-COLLECT or in DONE discards the partial or pending list. The state is IDLE on the next cycle.
- `Reset` takes priority over any simultaneous handshake.

## Configuration
- Macro: `REGLIST_DUP_CHECK_EN`.
- Defined: duplicate detection is active as described; `out_dup` is a sticky flag.
- Undefined: `out_dup` is tied to 0 and no compare logic is built. Duplicates merge silently into the mask, and count still counts distinct bits.

## Structure
- Package `reglist_pkg`:
  - `MASK_WIDTH` default constant.
  - Derived `IDX_WIDTH`.
  - State enum `reglist_state_t` {IDLE, COLLECT, DONE}.
- Sub-module `index_decoder`: combinational index → one-hot, plus an out-of-range flag. Parameterised by `IDX_WIDTH`/`MASK_WIDTH`.
- The top holds the FSM, accumulators and handshake.

## Test plan
- Beats 3, 5, 15 (last on 15), `out_ready`=1 → one cycle later `out_valid`=1, `out_mask`=16'h8028, `out_count`=3, `out_dup`=0, `out_err`=0; back to IDLE next cycle.
- Single beat idx 0 with last → `out_mask`=16'h0001, `out_count`=1.
- Beats 4, 4, 7 (last) with macro defined → `out_mask`=16'h0090, `out_count`=2, `out_dup`=1. Same stimulus without the macro → `out_dup`=0.
- `MASK_WIDTH`=12, beats 2, 13 (last) → `out_mask`=12'h004, `out_count`=1, `out_err`=1.
- Backpressure: DONE with `out_ready`=0 for 5 cycles while `in_valid`=1 → `in_ready`=0, outputs stable, the beat is accepted only after the handshake plus one cycle.
- All 16 indices in order, last on 15 → `out_mask`=16'hFFFF, `out_count`=16. Then assert `Reset` mid-list on a second list → next cycle state IDLE, all outputs 0.

Source files
------------

// File: rtl/reglist_decoder_pkg.sv
// Shared constants and state encoding for the register-list decoder.
package reglist_pkg;

  localparam int REGLIST_MASK_WIDTH = 16;
  localparam int REGLIST_IDX_WIDTH  = $clog2(REGLIST_MASK_WIDTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } reglist_state_t;

endpackage

// File: rtl/reglist_decoder_index_decoder.sv
// Combinational register index to one-hot decode with out-of-range flag.
module index_decoder #(
  parameter int IDX_WIDTH  = 4,
  parameter int MASK_WIDTH = 16
) (
  input  logic [IDX_WIDTH-1:0]  idx,
  output logic [MASK_WIDTH-1:0] onehot,
  output logic                  oor
);

  for (genvar i = 0; i < MASK_WIDTH; i++) begin : g_dec
    assign onehot[i] = (idx == IDX_WIDTH'(i));
  end

  // Extra bit so MASK_WIDTH == 2**IDX_WIDTH still compares correctly.
  assign oor = {1'b0, idx} >= (IDX_WIDTH+1)'(MASK_WIDTH);

endmodule

// File: rtl/reglist_decoder.sv
// Accumulates register indices into a register-list mask with count and flags.
// Optional duplicate detection: define REGLIST_DUP_CHECK_EN.
module reglist_decoder
  import reglist_pkg::*;
#(
  parameter int MASK_WIDTH = REGLIST_MASK_WIDTH,
  parameter int IDX_WIDTH  = $clog2(MASK_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IDX_WIDTH-1:0]  in_idx,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [MASK_WIDTH-1:0] out_mask,
  output logic [IDX_WIDTH:0]    out_count,
  output logic                  out_dup,
  output logic                  out_err
);

  reglist_state_t          state, nstate;
  logic [MASK_WIDTH-1:0]   onehot, mask;
  logic [IDX_WIDTH:0]      count;
  logic                    oor, hit, accept, clear, err, dup;

  index_decoder #(.IDX_WIDTH(IDX_WIDTH), .MASK_WIDTH(MASK_WIDTH)) u_dec (
    .idx    (in_idx),
    .onehot (onehot),
    .oor    (oor)
  );

  assign accept = in_valid && in_ready;
  assign clear  = (state == DONE) && out_ready;
  assign hit    = |(mask & onehot);

  always_ff @(posedge CLK) begin
    if (Reset) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE, COLLECT: if (accept) nstate = in_last ? DONE : COLLECT;
      DONE:          if (out_ready) nstate = IDLE;
      default:       nstate = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE, COLLECT: in_ready  = 1'b1;
      DONE:          out_valid = 1'b1;
      default:       in_ready  = 1'b0;
    endcase
  end

  // Release of a list and reset share the same clear so a new list starts clean.
  always_ff @(posedge CLK) begin
    if (Reset || clear) begin
      mask  <= '0;
      count <= '0;
      err   <= 1'b0;
    end else if (accept) begin
      if (oor) begin
        err <= 1'b1;
      end else begin
        mask <= mask | onehot;
        if (!hit) count <= count + 1'b1;
      end
    end
  end

`ifdef REGLIST_DUP_CHECK_EN
  always_ff @(posedge CLK) begin
    if (Reset || clear)             dup <= 1'b0;
    else if (accept && !oor && hit) dup <= 1'b1;
  end
`else
  assign dup = 1'b0;
`endif

  assign out_mask  = mask;
  assign out_count = count;
  assign out_dup   = dup;
  assign out_err   = err;

endmodule

// File: tb/tb_reglist_decoder.sv
// Scoreboard bench for reglist_decoder: default 16-wide instance plus a 12-wide one.
module tb_reglist_decoder;

  typedef struct {
    int mask;
    int count;
    int dup;
    int err;
  } exp_t;

`ifdef REGLIST_DUP_CHECK_EN
  localparam int DUP_EXP = 1;
`else
  localparam int DUP_EXP = 0;
`endif

  logic        clk = 1'b0;
  logic        Reset = 1'b1;

  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [3:0]  in_idx = '0;
  logic        in_ready, out_valid, out_dup, out_err;
  logic [15:0] out_mask;
  logic [4:0]  out_count;

  logic        v12 = 1'b0, l12 = 1'b0, ordy12 = 1'b1;
  logic [3:0]  i12 = '0;
  logic        rdy12, ov12, dup12, err12;
  logic [11:0] mask12;
  logic [4:0]  cnt12;

  exp_t q16[$];
  exp_t q12[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  reglist_decoder dut (
    .CLK(clk), .Reset(Reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_mask(out_mask),
    .out_count(out_count), .out_dup(out_dup), .out_err(out_err)
  );

  reglist_decoder #(.MASK_WIDTH(12)) dut12 (
    .CLK(clk), .Reset(Reset),
    .in_valid(v12), .in_ready(rdy12), .in_idx(i12), .in_last(l12),
    .out_valid(ov12), .out_ready(ordy12), .out_mask(mask12),
    .out_count(cnt12), .out_dup(dup12), .out_err(err12)
  );

  function automatic void chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic exp_t mk(input int m, input int c, input int d, input int e);
    exp_t x;
    x.mask = m; x.count = c; x.dup = d; x.err = e;
    return x;
  endfunction

  // Monitors: pop and compare on each delivered list.
  always @(negedge clk) begin
    if (!Reset && out_valid && out_ready) begin
      if (q16.size() == 0) begin
        chk("unexpected_list16", 1, 0);
      end else begin
        exp_t e;
        e = q16.pop_front();
        chk("mask16",  32'(out_mask),  e.mask);
        chk("count16", 32'(out_count), e.count);
        chk("dup16",   32'(out_dup),   e.dup);
        chk("err16",   32'(out_err),   e.err);
      end
    end
  end

  always @(negedge clk) begin
    if (!Reset && ov12 && ordy12) begin
      if (q12.size() == 0) begin
        chk("unexpected_list12", 1, 0);
      end else begin
        exp_t e;
        e = q12.pop_front();
        chk("mask12",  32'(mask12), e.mask);
        chk("count12", 32'(cnt12),  e.count);
        chk("dup12",   32'(dup12),  e.dup);
        chk("err12",   32'(err12),  e.err);
      end
    end
  end

  // Offer one beat and hold it until accepted (bounded); returns 1ns after the accepting edge.
  task automatic beat(input bit sel, input int idx, input bit last);
    int n = 0;
    if (sel) begin v12 = 1'b1; i12 = 4'(idx); l12 = last; end
    else     begin in_valid = 1'b1; in_idx = 4'(idx); in_last = last; end
    while (!(sel ? rdy12 : in_ready) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL beat_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
    end
    @(posedge clk); #1;
    if (sel) v12 = 1'b0; else in_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(in_ready),  1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_mask",      32'(out_mask),  0);
    chk("rst_count",     32'(out_count), 0);
    chk("rst_dup",       32'(out_dup),   0);
    chk("rst_err",       32'(out_err),   0);
    chk("rst_valid12",   32'(ov12),      0);
    Reset = 1'b0;
    @(posedge clk); #1;

    // Basic list with latency and return-to-idle checks.
    q16.push_back(mk(16'h8028, 3, 0, 0));
    beat(0, 3, 0); beat(0, 5, 0); beat(0, 15, 1);
    chk("lat_out_valid", 32'(out_valid), 1);
    chk("lat_in_ready",  32'(in_ready),  0);
    @(posedge clk); #1;
    chk("idle_out_valid", 32'(out_valid), 0);
    chk("idle_in_ready",  32'(in_ready),  1);

    q16.push_back(mk(16'h0001, 1, 0, 0));
    beat(0, 0, 1);
    @(posedge clk); #1;

    q16.push_back(mk(16'h0090, 2, DUP_EXP, 0));
    beat(0, 4, 0); beat(0, 4, 0); beat(0, 7, 1);
    @(posedge clk); #1;

    q12.push_back(mk(12'h004, 1, 0, 1));
    beat(1, 2, 0); beat(1, 13, 1);
    @(posedge clk); #1;

    // Backpressure: DONE held with a pending beat offered.
    out_ready = 1'b0;
    q16.push_back(mk(16'h0006, 2, 0, 0));
    beat(0, 1, 0); beat(0, 2, 1);
    in_valid = 1'b1; in_idx = 4'd9; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_in_ready",  32'(in_ready),  0);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_mask",      32'(out_mask),  16'h0006);
      chk("bp_count",     32'(out_count), 2);
      @(posedge clk); #1;
    end
    q16.push_back(mk(16'h0200, 1, 0, 0));
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready",  32'(in_ready),  1);
    chk("bp_release_out_valid", 32'(out_valid), 0);
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_next_valid", 32'(out_valid), 1);
    chk("bp_next_mask",  32'(out_mask),  16'h0200);
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Full list, then reset mid-way through a second one.
    q16.push_back(mk(16'hFFFF, 16, 0, 0));
    for (int i = 0; i < 16; i++) beat(0, i, i == 15);
    @(posedge clk); #1;
    beat(0, 1, 0); beat(0, 2, 0);
    chk("mid_mask", 32'(out_mask), 16'h0006);
    Reset = 1'b1;
    @(posedge clk); #1;
    Reset = 1'b0;
    chk("mrst_in_ready",  32'(in_ready),  1);
    chk("mrst_out_valid", 32'(out_valid), 0);
    chk("mrst_mask",      32'(out_mask),  0);
    chk("mrst_count",     32'(out_count), 0);
    chk("mrst_dup",       32'(out_dup),   0);
    chk("mrst_err",       32'(out_err),   0);

    repeat (3) @(posedge clk);
    #1;
    chk("q16_drained", q16.size(), 0);
    chk("q12_drained", q12.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
